// File: rtl/scandoubler_pkg.sv
// Shared video definitions for the scandoubler: default widths and the RGB pixel layout.
package scandoubler_pkg;

  localparam int COLOR_W_DEF = 6;
  localparam int HCNT_W_DEF  = 10;
  localparam int PIX_W_DEF   = 3 * COLOR_W_DEF;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  function automatic int pix_width(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/sd_line_buffer.sv
// Two-bank line store: synchronous write, registered read (1 clk latency), contents not reset.
module sd_line_buffer #(
  parameter int AW = 11,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scandoubler.sv
// Line-doubling scandoubler: each 15 kHz input line is stored once and replayed twice
// at the doubled pixel rate, with optional darkening of the second repeat.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int HCNT_W  = HCNT_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic               enable,
  input  logic               scanlines,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  input  logic               hs_in,
  input  logic               vs_in,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               hs_out,
  output logic               vs_out
);

  localparam int                PIX_W    = pix_width(COLOR_W);
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

  logic [HCNT_W-1:0] hcnt_in_reg, line_len_reg, hs_low_cnt_reg, hs_width_reg;
  logic [HCNT_W-1:0] hcnt_out_reg, line_last;
  logic              wbank_reg, hs_prev_reg, synced_reg, vs_line_reg, repeat_reg;
  logic              hs_fall, hs_rise;
  logic              hs_d1_reg, blank_d1_reg, dark_d1_reg, vs_d1_reg;
  logic [HCNT_W:0]   wr_addr, rd_addr;
  logic [PIX_W-1:0]  rd_data, pix_dark, pix_next, pix_out_reg;
  logic              hs_next, vs_next, hs_out_reg, vs_out_reg;

  assign hs_fall   = ce_pix & hs_prev_reg & ~hs_in;
  assign hs_rise   = ce_pix & ~hs_prev_reg & hs_in;
  assign line_last = line_len_reg - HCNT_ONE;

  // The pixel sampled on the hsync falling edge opens the new line at address 0 of the new bank.
  assign wr_addr = hs_fall ? {~wbank_reg, {HCNT_W{1'b0}}} : {wbank_reg, hcnt_in_reg};
  assign rd_addr = {~wbank_reg, hcnt_out_reg};

  sd_line_buffer #(
    .AW (HCNT_W + 1),
    .DW (PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (ce_pix),
    .waddr (wr_addr),
    .wdata ({red_in, green_in, blue_in}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_in_reg    <= '0;
      line_len_reg   <= '0;
      hs_low_cnt_reg <= '0;
      hs_width_reg   <= '0;
      wbank_reg      <= 1'b0;
      hs_prev_reg    <= 1'b1;
      synced_reg     <= 1'b0;
      vs_line_reg    <= 1'b1;
    end else if (ce_pix) begin
      hs_prev_reg <= hs_in;
      if (hs_fall) begin
        hcnt_in_reg  <= HCNT_ONE;
        wbank_reg    <= ~wbank_reg;
        // The line in progress at reset release is partial, so it is never displayed.
        line_len_reg <= synced_reg ? hcnt_in_reg : '0;
        synced_reg   <= 1'b1;
        vs_line_reg  <= vs_in;
      end else if (hcnt_in_reg != HCNT_MAX) begin
        hcnt_in_reg <= hcnt_in_reg + 1'b1;
      end
      if (hs_rise) begin
        hs_width_reg   <= hs_low_cnt_reg;
        hs_low_cnt_reg <= '0;
      end else if (!hs_in && hs_low_cnt_reg != HCNT_MAX) begin
        hs_low_cnt_reg <= hs_low_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_out_reg <= '0;
      repeat_reg   <= 1'b0;
    end else if (hs_fall) begin
      hcnt_out_reg <= '0;
      repeat_reg   <= 1'b0;
    end else if (line_len_reg == '0) begin
      hcnt_out_reg <= '0;
    end else if (hcnt_out_reg == line_last) begin
      hcnt_out_reg <= '0;
      repeat_reg   <= ~repeat_reg;
    end else begin
      hcnt_out_reg <= hcnt_out_reg + 1'b1;
    end
  end

  // Sync and control travel one stage alongside the RAM read so they meet the pixel at the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d1_reg    <= 1'b1;
      blank_d1_reg <= 1'b1;
      dark_d1_reg  <= 1'b0;
      vs_d1_reg    <= 1'b1;
    end else begin
      hs_d1_reg    <= !(hcnt_out_reg < hs_width_reg);
      blank_d1_reg <= (line_len_reg == '0);
      dark_d1_reg  <= scanlines & repeat_reg;
      vs_d1_reg    <= vs_line_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dark
      logic [COLOR_W-1:0] chan;
      assign chan = rd_data[gi*COLOR_W +: COLOR_W];
      assign pix_dark[gi*COLOR_W +: COLOR_W] = dark_d1_reg ? {1'b0, chan[COLOR_W-1:1]} : chan;
    end
  endgenerate

  always_comb begin
    pix_next = pix_dark;
    hs_next  = hs_d1_reg;
    vs_next  = vs_d1_reg;
    if (!enable) begin
      pix_next = {red_in, green_in, blue_in};
      hs_next  = hs_in;
      vs_next  = vs_in;
    end else if (blank_d1_reg) begin
      pix_next = '0;
      hs_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out_reg <= '0;
      hs_out_reg  <= 1'b1;
      vs_out_reg  <= 1'b1;
    end else begin
      pix_out_reg <= pix_next;
      hs_out_reg  <= hs_next;
      vs_out_reg  <= vs_next;
    end
  end

  assign red_out   = pix_out_reg[2*COLOR_W +: COLOR_W];
  assign green_out = pix_out_reg[COLOR_W +: COLOR_W];
  assign blue_out  = pix_out_reg[0 +: COLOR_W];
  assign hs_out    = hs_out_reg;
  assign vs_out    = vs_out_reg;

endmodule

// File: tb/tb_scandoubler.sv
// Directed bench for scandoubler: drives whole input lines, captures every output clock,
// and compares against values derived from the pixels it drove on the previous line.
module tb_scandoubler;
  import scandoubler_pkg::*;

  localparam int CW      = 6;
  localparam int MAXN    = 1100;
  localparam int LEN_MAX = 1023;
  localparam int HS_LOW  = 26;
  localparam int NLINE   = 342;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b0;
  logic          enable = 1'b1;
  logic          scanlines = 1'b0;
  logic [CW-1:0] red_in = '0, green_in = '0, blue_in = '0;
  logic          hs_in = 1'b1, vs_in = 1'b1;
  logic [CW-1:0] red_out, green_out, blue_out;
  logic          hs_out, vs_out;

  scandoubler #(.HCNT_W(10), .COLOR_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .enable    (enable),
    .scanlines (scanlines),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .red_out   (red_out),
    .green_out (green_out),
    .blue_out  (blue_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int line_no  = 0;

  logic [17:0] cap_pix [0:2*MAXN-1];
  logic        cap_hs  [0:2*MAXN-1];
  logic        cap_vs  [0:2*MAXN-1];
  logic [17:0] drv_pix [0:2*MAXN-1];
  logic        drv_hs  [0:2*MAXN-1];
  logic        drv_vs  [0:2*MAXN-1];
  logic [17:0] cur_data  [0:MAXN-1];
  logic [17:0] prev_data [0:MAXN-1];
  int          cur_n = 0, prev_n = 0;
  logic        cur_vs = 1'b1, prev_vs = 1'b1;

  function automatic rgb_t pixel(input int mode, input int p);
    rgb_t px;
    if (mode == 1) begin
      px.r = 6'h3F; px.g = 6'h3F; px.b = 6'h3F;
    end else begin
      px.r = 6'(p % 64);
      px.g = 6'((p + 21) % 64);
      px.b = 6'(63 - (p % 64));
    end
    return px;
  endfunction

  function automatic logic [17:0] dark(input logic [17:0] v);
    return {1'b0, v[17:13], 1'b0, v[11:7], 1'b0, v[5:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One input line: hs low for the first HS_LOW pixels, vs_a before mid-line, vs_b after.
  task automatic run_line(input int n, input int mode, input logic vs_a, input logic vs_b,
                          input logic en, input logic scan);
    rgb_t px;
    for (int p = 0; p < cur_n; p++) prev_data[p] = cur_data[p];
    prev_n  = cur_n;
    prev_vs = cur_vs;
    cur_n   = n;
    cur_vs  = vs_a;
    for (int j = 0; j < 2*n; j++) begin
      @(negedge clk);
      cap_pix[j] = {red_out, green_out, blue_out};
      cap_hs[j]  = hs_out;
      cap_vs[j]  = vs_out;
      enable     = en;
      scanlines  = scan;
      if (j % 2 == 0) begin
        px          = pixel(mode, j/2);
        red_in      = px.r;
        green_in    = px.g;
        blue_in     = px.b;
        hs_in       = (j/2 < HS_LOW) ? 1'b0 : 1'b1;
        vs_in       = (j/2 < n/2) ? vs_a : vs_b;
        ce_pix      = 1'b1;
        cur_data[j/2] = px;
      end else begin
        ce_pix = 1'b0;
      end
      drv_pix[j] = {red_in, green_in, blue_in};
      drv_hs[j]  = hs_in;
      drv_vs[j]  = vs_in;
    end
    line_no++;
    $display("line %0d: %0d pixels mode=%0d vs=%0d/%0d enable=%0d scanlines=%0d",
             line_no, n, mode, vs_a, vs_b, en, scan);
  endtask

  task automatic check_blank(input string tag, input int lo, input int hi);
    int nb_p, nb_h, nb_v;
    nb_p = 0; nb_h = 0; nb_v = 0;
    for (int j = lo; j <= hi; j++) begin
      if (cap_pix[j] !== 18'h0) nb_p++;
      if (cap_hs[j] !== 1'b1) nb_h++;
      if (cap_vs[j] !== 1'b1) nb_v++;
    end
    check({tag, " blank pixel mismatches"}, nb_p, 0);
    check({tag, " blank hs mismatches"}, nb_h, 0);
    check({tag, " blank vs mismatches"}, nb_v, 0);
  endtask

  // Output line starts 3 captures into the input line; each repeat lasts line_len clocks.
  task automatic check_doubled(input string tag, input logic scan);
    int len, last, k, h;
    int nb_p, nb_h, nb_v, fj_p, fj_h, fj_v;
    logic [17:0] e, fo_p, fe_p;
    logic eh;
    len  = (prev_n > LEN_MAX) ? LEN_MAX : prev_n;
    last = 2*cur_n - 1;
    if (last > 2*len + 2) last = 2*len + 2;
    nb_p = 0; nb_h = 0; nb_v = 0; fj_p = -1; fj_h = -1; fj_v = -1;
    fo_p = '0; fe_p = '0;
    for (int j = 3; j <= last; j++) begin
      k  = j - 3;
      h  = k % len;
      e  = prev_data[h];
      if (scan && k >= len) e = dark(e);
      eh = (h < HS_LOW) ? 1'b0 : 1'b1;
      if (cap_pix[j] !== e) begin
        if (nb_p == 0) begin fj_p = j; fo_p = cap_pix[j]; fe_p = e; end
        nb_p++;
      end
      if (cap_hs[j] !== eh) begin
        if (nb_h == 0) fj_h = j;
        nb_h++;
      end
      if (cap_vs[j] !== cur_vs) begin
        if (nb_v == 0) fj_v = j;
        nb_v++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (cap_vs[j] !== prev_vs) begin
        if (nb_v == 0) fj_v = j;
        nb_v++;
      end
    end
    check($sformatf("%s pixel mismatches (first clk %0d got %h want %h)", tag, fj_p, fo_p, fe_p), nb_p, 0);
    check($sformatf("%s hs mismatches (first clk %0d)", tag, fj_h), nb_h, 0);
    check($sformatf("%s vs mismatches (first clk %0d)", tag, fj_v), nb_v, 0);
  endtask

  task automatic check_bypass(input string tag);
    int nb_p, nb_h, nb_v;
    nb_p = 0; nb_h = 0; nb_v = 0;
    for (int j = 1; j < 2*cur_n; j++) begin
      if (cap_pix[j] !== drv_pix[j-1]) nb_p++;
      if (cap_hs[j] !== drv_hs[j-1]) nb_h++;
      if (cap_vs[j] !== drv_vs[j-1]) nb_v++;
    end
    check({tag, " bypass pixel mismatches"}, nb_p, 0);
    check({tag, " bypass hs mismatches"}, nb_h, 0);
    check({tag, " bypass vs mismatches"}, nb_v, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vs_tab_a [0:5];
    logic vs_tab_b [0:5];
    logic [17:0] before_rst;

    // Reset held with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset pixel", {red_out, green_out, blue_out}, 18'h0);
      check("reset hs", hs_out, 1'b1);
      check("reset vs", vs_out, 1'b1);
      {red_in, green_in, blue_in} = 18'($urandom);
      hs_in     = 1'($urandom);
      vs_in     = 1'($urandom);
      ce_pix    = 1'($urandom);
      enable    = 1'($urandom);
      scanlines = 1'($urandom);
    end
    $display("reset phase: 8 clocks with random inputs");

    @(negedge clk);
    reset_n = 1'b1; enable = 1'b1; scanlines = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; ce_pix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle after reset pixel", {red_out, green_out, blue_out}, 18'h0);
      check("idle after reset hs", hs_out, 1'b1);
      ce_pix = ~ce_pix;
    end
    $display("idle: 10 clocks, hs high");

    // First falling edge: partial line, output stays blank through it
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_blank("first line", 0, 2*NLINE-1);

    // Second falling edge: doubling starts after the 2-clk pipeline
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("second line pre-start pixel", cap_pix[2], 18'h0);
    check("second line pre-start hs", cap_hs[2], 1'b1);
    check("second line first pixel", cap_pix[3], 18'h00FFF & {6'd0, 6'd21, 6'd63});
    check_doubled("ramp line 2", 1'b0);
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_doubled("ramp line 3", 1'b0);

    // Scanlines: second repeat halved
    run_line(NLINE, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_doubled("scan over ramp", 1'b1);
    run_line(NLINE, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("scan first repeat", cap_pix[3], {3{6'h3F}});
    check("scan second repeat", cap_pix[3+NLINE], {3{6'h1F}});
    check_doubled("scan constant", 1'b1);

    // vsync low from mid-line of the first entry to mid-line of the fourth
    vs_tab_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vs_tab_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int v = 0; v < 6; v++) begin
      run_line(NLINE, 0, vs_tab_a[v], vs_tab_b[v], 1'b1, 1'b0);
      check_doubled($sformatf("vsync line %0d", v), 1'b0);
    end

    // Overflow: 1100 pixels saturate at 1023
    run_line(MAXN, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_doubled("overflow line 1", 1'b0);
    run_line(MAXN, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_doubled("overflow line 2", 1'b0);
    check("overflow second repeat hs start", cap_hs[3+LEN_MAX], 1'b0);
    check("overflow first repeat hs end", cap_hs[2+LEN_MAX], 1'b1);
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_doubled("after overflow", 1'b0);

    // Bypass, then re-enable
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_bypass("bypass line 1");
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_bypass("bypass line 2");
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_line(NLINE, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_doubled("re-enabled", 1'b0);

    // Asynchronous reset in the middle of a displayed line
    ce_pix = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    before_rst = {red_out, green_out, blue_out};
    check("pixel active before mid-line reset", (before_rst != 18'h0), 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid-line reset pixel", {red_out, green_out, blue_out}, 18'h0);
    check("mid-line reset hs", hs_out, 1'b1);
    check("mid-line reset vs", vs_out, 1'b1);
    $display("mid-line reset applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
